// File: rtl/uart_top.sv
// Button-triggered UART greeter: a btn rising edge sends "Hello\r\n" as 8N1 frames on tx.
// tx falls 3 clocks after btn is first sampled high; triggers are dropped (not queued) while busy.
module uart_top #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic btn,
  output logic tx,
  output logic led
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [2:0]    LAST_IDX  = 3'd6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {SQ_IDLE, SQ_SEND, SQ_WAIT} sq_state_t;

  function automatic logic [7:0] msg_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    msg_byte = 8'h48;
      3'd1:    msg_byte = 8'h65;
      3'd2:    msg_byte = 8'h6C;
      3'd3:    msg_byte = 8'h6C;
      3'd4:    msg_byte = 8'h6F;
      3'd5:    msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  // Button synchronizer and rising-edge detector
  logic sync1_q, sync2_q, prev_q;
  logic trig;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign trig = sync2_q & ~prev_q;

  // Sequencer-to-transmitter handshake
  tx_state_t      tx_state_q;
  sq_state_t      sq_state_q;
  logic [CW-1:0]  baud_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           byte_vld_q;
  logic [7:0]     byte_dat_q;
  logic [2:0]     idx_q;
  logic           led_q;
  logic           tx_rdy;
  logic           byte_acc;
  logic           baud_last;
  logic           byte_done;

  assign tx_rdy    = (tx_state_q == TX_IDLE);
  assign byte_acc  = byte_vld_q & tx_rdy;
  assign baud_last = (baud_q == BAUD_LAST);
  assign byte_done = (tx_state_q == TX_STOP) & baud_last;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= 3'd0;
          if (byte_vld_q) begin
            shift_q    <= byte_dat_q;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_last) begin
            baud_q     <= '0;
            tx_q       <= shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q      <= 3'd0;
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              // Shift register keeps the next bit at position 1
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_STOP: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q     <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          tx_q       <= 1'b1;
          baud_q     <= '0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      sq_state_q <= SQ_IDLE;
      idx_q      <= 3'd0;
      byte_vld_q <= 1'b0;
      byte_dat_q <= 8'h00;
      led_q      <= 1'b0;
    end else begin
      case (sq_state_q)
        SQ_IDLE: begin
          if (trig) begin
            idx_q      <= 3'd0;
            byte_dat_q <= msg_byte(3'd0);
            byte_vld_q <= 1'b1;
            sq_state_q <= SQ_SEND;
          end
        end
        SQ_SEND: begin
          if (byte_acc) begin
            byte_vld_q <= 1'b0;
            sq_state_q <= SQ_WAIT;
            if (idx_q == 3'd0) led_q <= 1'b1;
          end
        end
        SQ_WAIT: begin
          // led drops on the same edge the final stop bit ends
          if (byte_done) begin
            if (idx_q == LAST_IDX) begin
              idx_q      <= 3'd0;
              led_q      <= 1'b0;
              sq_state_q <= SQ_IDLE;
            end else begin
              idx_q      <= idx_q + 3'd1;
              byte_dat_q <= msg_byte(idx_q + 3'd1);
              byte_vld_q <= 1'b1;
              sq_state_q <= SQ_SEND;
            end
          end
        end
        default: begin
          byte_vld_q <= 1'b0;
          led_q      <= 1'b0;
          sq_state_q <= SQ_IDLE;
        end
      endcase
    end
  end

  assign tx  = tx_q;
  assign led = led_q;

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: default-rate instance plus a fast-rate instance (10 clocks/bit).
module tb_uart_top;

  logic hwclk = 1'b0;
  logic rst_n, btn, rst2_n, btn2;
  logic tx1, led1, tx2, led2;
  logic tx_mon, led_mon;
  int   sel = 0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] d;
  int         bad, lat;
  logic       ls;
  logic [7:0] msg [7];

  always #5 hwclk = ~hwclk;

  uart_top dut (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .btn   (btn),
    .tx    (tx1),
    .led   (led1)
  );

  uart_top #(.CLK_FREQ(1000000), .BAUD(100000)) dut2 (
    .hwclk (hwclk),
    .rst_n (rst2_n),
    .btn   (btn2),
    .tx    (tx2),
    .led   (led2)
  );

  assign tx_mon  = (sel == 1) ? tx2  : tx1;
  assign led_mon = (sel == 1) ? led2 : led1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a start bit, then samples one frame on falling edges.
  task automatic rx_byte(input int cpb, input int limit, output logic [7:0] dat,
                         output int nbad, output int nlat, output logic led_start);
    logic v;
    dat = 8'h00; nbad = 0; nlat = 0; led_start = 1'b0;
    while (tx_mon !== 1'b0 && nlat < limit) begin
      @(negedge hwclk);
      nlat++;
    end
    if (tx_mon !== 1'b0) begin
      nbad = 999;
    end else begin
      led_start = led_mon;
      for (int b = 0; b < 10; b++) begin
        v = tx_mon;
        for (int c = 0; c < cpb; c++) begin
          if (tx_mon !== v) nbad++;
          @(negedge hwclk);
        end
        if (b == 0) begin
          if (v !== 1'b0) nbad++;
        end else if (b == 9) begin
          if (v !== 1'b1) nbad++;
        end else begin
          dat = {v, dat[7:1]};
        end
      end
    end
  endtask

  task automatic watch_idle(input int n, output int nbad);
    nbad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge hwclk);
      if (tx_mon !== 1'b1 || led_mon !== 1'b0) nbad++;
    end
  endtask

  initial begin
    msg[0] = 8'h48; msg[1] = 8'h65; msg[2] = 8'h6C; msg[3] = 8'h6C;
    msg[4] = 8'h6F; msg[5] = 8'h0D; msg[6] = 8'h0A;
    rst_n = 1'b0; btn = 1'b0; rst2_n = 1'b0; btn2 = 1'b0;

    repeat (3) @(negedge hwclk);
    check("reset_tx",   {31'd0, tx1},  1);
    check("reset_led",  {31'd0, led1}, 0);
    check("reset2_tx",  {31'd0, tx2},  1);
    check("reset2_led", {31'd0, led2}, 0);

    rst_n = 1'b1;
    watch_idle(178, bad);
    check("idle_178", bad, 0);

    // Message 1 with btn held; a short low pulse lands inside byte 2
    btn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        fork
          rx_byte(104, 10, d, bad, lat, ls);
          begin
            repeat (400) @(negedge hwclk);
            btn = 1'b0;
            repeat (3) @(negedge hwclk);
            btn = 1'b1;
          end
        join
      end else begin
        rx_byte(104, (i == 0) ? 20 : 10, d, bad, lat, ls);
      end
      check($sformatf("m1_byte%0d", i), {24'd0, d}, {24'd0, msg[i]});
      check($sformatf("m1_bits%0d", i), bad, 0);
      if (i == 0) begin
        check("m1_latency_le5", {31'd0, (lat <= 5)}, 1);
        check("m1_led_rise",    {31'd0, ls}, 1);
      end else begin
        check($sformatf("m1_gap%0d_le2", i), {31'd0, (lat <= 2)}, 1);
      end
    end
    check("m1_led_fall", {31'd0, led1}, 0);
    watch_idle(1500, bad);
    check("m1_no_repeat", bad, 0);

    // Message 2, aborted by reset during byte 3
    btn = 1'b0;
    repeat (3) @(negedge hwclk);
    btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_byte(104, 20, d, bad, lat, ls);
      check($sformatf("m2_byte%0d", i), {24'd0, d}, {24'd0, msg[i]});
    end
    lat = 0;
    while (tx1 !== 1'b0 && lat < 10) begin
      @(negedge hwclk);
      lat++;
    end
    check("m2_byte3_start", {31'd0, tx1}, 0);
    repeat (300) @(negedge hwclk);
    check("m2_led_busy", {31'd0, led1}, 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx",  {31'd0, tx1},  1);
    check("abort_led", {31'd0, led1}, 0);
    @(negedge hwclk);
    btn = 1'b0;
    repeat (5) @(negedge hwclk);
    rst_n = 1'b1;
    watch_idle(2000, bad);
    check("abort_quiet", bad, 0);

    // Fast instance released with btn already high: exactly one message
    sel = 1;
    btn2 = 1'b1;
    repeat (3) @(negedge hwclk);
    rst2_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rx_byte(10, 20, d, bad, lat, ls);
      check($sformatf("f_byte%0d", i), {24'd0, d}, {24'd0, msg[i]});
      check($sformatf("f_bits%0d", i), bad, 0);
    end
    check("f_led_fall", {31'd0, led2}, 0);
    watch_idle(300, bad);
    check("f_no_repeat", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
